ss_display_arbiter: RTL



---
 rtl/ss_display_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ss_display_arbiter.sv
// Round-robin arbiter that shares one ss_display between NUM_REQ requesters.
// Optional post-refresh dwell hold-off is enabled with `define SS_ARB_DWELL_EN.
module ss_display_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_DISPLAYS = 6,
  parameter int DWELL_CYCLES = 16
) (
  input  logic                                      CLK,
  input  logic                                      nRST,
  input  logic [NUM_REQ-1:0]                        req,
  input  logic [NUM_REQ-1:0][4*NUM_DISPLAYS-1:0]    req_number,
  input  logic [NUM_REQ-1:0][NUM_DISPLAYS-1:0]      req_en_mask,
  output logic [NUM_REQ-1:0]                        grant,
  output logic                                      load_enable,
  output logic [4*NUM_DISPLAYS-1:0]                 number,
  output logic [NUM_DISPLAYS-1:0]                   en_mask,
  output logic                                      busy,
  output logic [$clog2(NUM_REQ)-1:0]                owner
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int SUM_W   = IDX_W + 1;
  localparam int CNT_MAX = (NUM_DISPLAYS > DWELL_CYCLES) ? NUM_DISPLAYS : DWELL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2
`ifdef SS_ARB_DWELL_EN
    , S_DWELL = 2'd3
`endif
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [IDX_W-1:0]          owner_q, owner_d;
  logic [4*NUM_DISPLAYS-1:0] number_q, number_d;
  logic [NUM_DISPLAYS-1:0]   en_mask_q, en_mask_d;

  logic                      win_valid;
  logic [IDX_W-1:0]          win_idx;
  logic [SUM_W-1:0]          cand;

  // Search ptr+1, ptr+2, ... modulo NUM_REQ; the first pending request wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + SUM_W'(i);
      if (cand >= SUM_W'(NUM_REQ)) cand = cand - SUM_W'(NUM_REQ);
      if (!win_valid && req[cand[IDX_W-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its peers, independent of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      owner_q   <= '0;
      number_q  <= '0;
      en_mask_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      number_q  <= number_d;
      en_mask_q <= en_mask_d;
    end
  end

  // NOTE: every signal gets a hold-value default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    number_d  = number_q;
    en_mask_d = en_mask_q;
    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          state_d   = S_LOAD;
          ptr_d     = win_idx;
          owner_d   = win_idx;
          number_d  = req_number[win_idx];
          en_mask_d = req_en_mask[win_idx];
        end
      end
      S_LOAD: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(NUM_DISPLAYS - 1)) begin
          cnt_d   = '0;
`ifdef SS_ARB_DWELL_EN
          state_d = (DWELL_CYCLES > 0) ? S_DWELL : S_IDLE;
`else
          state_d = S_IDLE;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef SS_ARB_DWELL_EN
      S_DWELL: begin
        if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    load_enable = (state_q == S_LOAD);
    busy        = (state_q != S_IDLE);
    grant       = '0;
    if (state_q == S_LOAD) grant[owner_q] = 1'b1;
  end

  assign number  = number_q;
  assign en_mask = en_mask_q;
  assign owner   = owner_q;

endmodule
